// File: rtl/ccu_cd_arbiter_if.sv
// Bundles the push, CD and consumer signals of ccu_cd_arbiter.
// Signal suffixes are seen from the arbiter (slave) side.
//   push_*  : descriptor enqueue handshake {user, first, avail}
//   cd_*    : per-port CD beat channels (port i in slice i of cd_data_i)
//   usr_*   : forwarded beat towards the consumers (data shared, valid per user)
//   busy_o, beat_err_o : status
// Modports: slave = arbiter, master = environment driving it.
interface ccu_cd_arbiter_if #(
    parameter int unsigned NoMstPorts  = 4,
    parameter int unsigned NoUsers     = 2,
    parameter int unsigned CdDataWidth = 64
);
    localparam int unsigned UserW = (NoUsers > 1) ? $clog2(NoUsers) : 1;
    localparam int unsigned PortW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;

    logic                              push_valid_i;
    logic                              push_ready_o;
    logic [UserW-1:0]                  push_user_i;
    logic [PortW-1:0]                  push_first_i;
    logic [NoMstPorts-1:0]             push_avail_i;
    logic [NoMstPorts-1:0]             cd_valid_i;
    logic [NoMstPorts-1:0]             cd_ready_o;
    logic [NoMstPorts*CdDataWidth-1:0] cd_data_i;
    logic [NoMstPorts-1:0]             cd_last_i;
    logic [NoUsers-1:0]                usr_valid_o;
    logic [NoUsers-1:0]                usr_ready_i;
    logic [CdDataWidth-1:0]            usr_data_o;
    logic                              usr_last_o;
    logic                              busy_o;
    logic                              beat_err_o;

    modport slave (
        input  push_valid_i, push_user_i, push_first_i, push_avail_i,
        input  cd_valid_i, cd_data_i, cd_last_i, usr_ready_i,
        output push_ready_o, cd_ready_o, usr_valid_o, usr_data_o, usr_last_o,
        output busy_o, beat_err_o
    );

    modport master (
        output push_valid_i, push_user_i, push_first_i, push_avail_i,
        output cd_valid_i, cd_data_i, cd_last_i, usr_ready_i,
        input  push_ready_o, cd_ready_o, usr_valid_o, usr_data_o, usr_last_o,
        input  busy_o, beat_err_o
    );
endinterface

// File: rtl/ccu_cd_arbiter.sv
// Snoop CD-data arbiter. Descriptors {user, first, avail} are queued in
// order; only the head descriptor is serviced. Every port in avail must
// deliver one full line; the data of port "first" is forwarded to consumer
// "user", data of the other responders is drained and discarded. The head
// pops once every available port has delivered its last beat.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : ccu_cd_arbiter_if.slave (push, CD, consumer and status signals)
module ccu_cd_arbiter #(
    parameter int unsigned NoMstPorts  = 4,
    parameter int unsigned NoUsers     = 2,
    parameter int unsigned Depth       = 4,
    parameter int unsigned LineBeats   = 2,
    parameter int unsigned CdDataWidth = 64,
    parameter int unsigned FallThrough = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ccu_cd_arbiter_if.slave      bus
);
    localparam int unsigned UserW  = (NoUsers > 1) ? $clog2(NoUsers) : 1;
    localparam int unsigned PortW  = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;
    localparam int unsigned CntW   = (LineBeats > 1) ? $clog2(LineBeats) : 1;
    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned CountW = $clog2(Depth + 1);

    logic [UserW-1:0]      q_user  [Depth];
    logic [PortW-1:0]      q_first [Depth];
    logic [NoMstPorts-1:0] q_avail [Depth];
    logic [PtrW-1:0]       wr_ptr, rd_ptr;
    logic [CountW-1:0]     count;

    logic [NoMstPorts-1:0] done_q;
    logic [CntW-1:0]       cnt_q [NoMstPorts];
    logic                  beat_err_q;

    logic                  full, empty, push, bypass, q_write, q_read, pop;
    logic                  head_valid;
    logic [UserW-1:0]      head_user;
    logic [PortW-1:0]      head_first;
    logic [NoMstPorts-1:0] head_avail;
    logic [NoMstPorts-1:0] cd_ready, hs, hs_last;
    logic [NoUsers-1:0]    usr_valid;
    logic [CdDataWidth-1:0] usr_data;
    logic                  usr_last;
    logic                  err_any;

    assign full   = (count == CountW'(Depth));
    assign empty  = (count == '0);
    // No push while full, even if the head pops in the same cycle.
    assign push   = bus.push_valid_i && !full && !rst_i;
    // With fall-through, an empty queue presents the incoming descriptor as head.
    assign bypass = (FallThrough != 0) && empty;

    always_comb begin
        head_user  = q_user[rd_ptr];
        head_first = q_first[rd_ptr];
        head_avail = q_avail[rd_ptr];
        head_valid = !empty && !rst_i;
        if (bypass) begin
            head_user  = bus.push_user_i;
            head_first = bus.push_first_i;
            head_avail = bus.push_avail_i;
            head_valid = push;
        end
    end

    always_comb begin
        cd_ready = '0;
        usr_valid = '0;
        usr_data = '0;
        usr_last = 1'b0;
        err_any = 1'b0;
        for (int i = 0; i < NoMstPorts; i++) begin
            // The forwarded port is back-pressured by its consumer; the others
            // are drained unconditionally.
            cd_ready[i] = head_valid && head_avail[i] && !done_q[i] &&
                          ((PortW'(i) != head_first) || bus.usr_ready_i[head_user]);
            if (PortW'(i) == head_first) begin
                usr_data = bus.cd_data_i[i*CdDataWidth +: CdDataWidth];
                usr_last = bus.cd_last_i[i];
            end
        end
        hs      = cd_ready & bus.cd_valid_i;
        hs_last = hs & bus.cd_last_i;
        for (int i = 0; i < NoMstPorts; i++) begin
            if (hs[i] && (bus.cd_last_i[i] != (cnt_q[i] == CntW'(LineBeats - 1))))
                err_any = 1'b1;
        end
        if (head_valid && head_avail[head_first] && !done_q[head_first] &&
            bus.cd_valid_i[head_first])
            usr_valid[head_user] = 1'b1;
    end

    // avail == 0 satisfies this immediately, so such a head pops at once.
    assign pop     = head_valid && (((done_q | hs_last) & head_avail) == head_avail);
    assign q_write = push && !(bypass && pop);
    assign q_read  = pop && !bypass;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            done_q     <= '0;
            beat_err_q <= 1'b0;
            for (int i = 0; i < NoMstPorts; i++) cnt_q[i] <= '0;
            for (int d = 0; d < Depth; d++) begin
                q_user[d]  <= '0;
                q_first[d] <= '0;
                q_avail[d] <= '0;
            end
        end else begin
            beat_err_q <= err_any;
            if (q_write) begin
                q_user[wr_ptr]  <= bus.push_user_i;
                q_first[wr_ptr] <= bus.push_first_i;
                q_avail[wr_ptr] <= bus.push_avail_i;
                wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
            end
            if (q_read)
                rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
            case ({q_write, q_read})
                2'b10:   count <= count + CountW'(1);
                2'b01:   count <= count - CountW'(1);
                default: count <= count;
            endcase
            if (pop) begin
                done_q <= '0;
                for (int i = 0; i < NoMstPorts; i++) cnt_q[i] <= '0;
            end else begin
                for (int i = 0; i < NoMstPorts; i++) begin
                    if (hs[i]) begin
                        if (bus.cd_last_i[i]) begin
                            done_q[i] <= 1'b1;
                            cnt_q[i]  <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CntW'(1);
                        end
                    end
                end
            end
        end
    end

    assign bus.push_ready_o = !full || rst_i;
    assign bus.cd_ready_o   = cd_ready;
    assign bus.usr_valid_o  = usr_valid;
    assign bus.usr_data_o   = usr_data;
    assign bus.usr_last_o   = usr_last;
    assign bus.busy_o       = !empty && !rst_i;
    assign bus.beat_err_o   = beat_err_q && !rst_i;
endmodule

// File: tb/tb_ccu_cd_arbiter.sv
module tb_ccu_cd_arbiter;
    localparam int NP = 4;
    localparam int NU = 2;
    localparam int DEPTH = 4;
    localparam int LB = 2;
    localparam int W = 64;

    typedef struct {
        int unsigned   user;
        int unsigned   first;
        logic [NP-1:0] avail;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    ccu_cd_arbiter_if #(.NoMstPorts(NP), .NoUsers(NU), .CdDataWidth(W)) bus ();

    ccu_cd_arbiter #(
        .NoMstPorts(NP), .NoUsers(NU), .Depth(DEPTH), .LineBeats(LB),
        .CdDataWidth(W), .FallThrough(0)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push_valid_i = 1'b0;
        bus.push_user_i  = '0;
        bus.push_first_i = '0;
        bus.push_avail_i = '0;
        bus.cd_valid_i   = '0;
        bus.cd_last_i    = '0;
        bus.cd_data_i    = '0;
    endtask

    task automatic set_data(input int p, input logic [W-1:0] d);
        bus.cd_data_i[p*W +: W] = d;
    endtask

    task automatic push_one(input int u, input int f, input logic [NP-1:0] a);
        bus.push_valid_i = 1'b1;
        bus.push_user_i  = u[0:0];
        bus.push_first_i = f[1:0];
        bus.push_avail_i = a;
        tick();
        bus.push_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.usr_ready_i = '1;
        tick();
        tick();
        @(negedge clk);
        checks++; if (bus.push_ready_o !== 1'b1) begin errors++; $display("FAIL rst_push_ready got %0b exp 1", bus.push_ready_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", bus.busy_o); end
        checks++; if (bus.cd_ready_o !== 4'b0000) begin errors++; $display("FAIL rst_cd_ready got %b exp 0000", bus.cd_ready_o); end
        checks++; if (bus.usr_valid_o !== 2'b00) begin errors++; $display("FAIL rst_usr_valid got %b exp 00", bus.usr_valid_o); end
        checks++; if (bus.beat_err_o !== 1'b0) begin errors++; $display("FAIL rst_beat_err got %0b exp 0", bus.beat_err_o); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [W-1:0] b1, b2;
        b1 = {$urandom, $urandom};
        b2 = {$urandom, $urandom};
        bus.usr_ready_i = 2'b11;
        push_one(1, 2, 4'b0110);
        bus.cd_valid_i = 4'b0110; bus.cd_last_i = 4'b0000;
        set_data(1, {$urandom, $urandom}); set_data(2, b1);
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b exp 1", bus.busy_o); end
        checks++; if (bus.cd_ready_o !== 4'b0110) begin errors++; $display("FAIL basic_ready1 got %b exp 0110", bus.cd_ready_o); end
        checks++; if (bus.usr_valid_o !== 2'b10) begin errors++; $display("FAIL basic_uvalid1 got %b exp 10", bus.usr_valid_o); end
        checks++; if (bus.usr_data_o !== b1) begin errors++; $display("FAIL basic_data1 got %h exp %h", bus.usr_data_o, b1); end
        checks++; if (bus.usr_last_o !== 1'b0) begin errors++; $display("FAIL basic_last1 got %0b exp 0", bus.usr_last_o); end
        tick();
        bus.cd_valid_i = 4'b0100; bus.cd_last_i = 4'b0100; set_data(2, b2);
        @(negedge clk);
        checks++; if (bus.cd_ready_o !== 4'b0110) begin errors++; $display("FAIL basic_ready2 got %b exp 0110", bus.cd_ready_o); end
        checks++; if (bus.usr_data_o !== b2) begin errors++; $display("FAIL basic_data2 got %h exp %h", bus.usr_data_o, b2); end
        checks++; if (bus.usr_last_o !== 1'b1) begin errors++; $display("FAIL basic_last2 got %0b exp 1", bus.usr_last_o); end
        tick();
        bus.cd_valid_i = 4'b0010; bus.cd_last_i = 4'b0010; set_data(1, {$urandom, $urandom});
        @(negedge clk);
        checks++; if (bus.cd_ready_o !== 4'b0010) begin errors++; $display("FAIL basic_ready3 got %b exp 0010", bus.cd_ready_o); end
        checks++; if (bus.usr_valid_o !== 2'b00) begin errors++; $display("FAIL basic_uvalid3 got %b exp 00", bus.usr_valid_o); end
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy3 got %0b exp 1", bus.busy_o); end
        tick();
        idle();
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL basic_pop got %0b exp 0", bus.busy_o); end
        checks++; if (bus.cd_ready_o !== 4'b0000) begin errors++; $display("FAIL basic_ready_end got %b exp 0000", bus.cd_ready_o); end
        tick();
    endtask

    task automatic test_stall();
        logic [W-1:0] d1, d2;
        int fwd;
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        fwd = 0;
        bus.usr_ready_i = 2'b01;
        push_one(1, 2, 4'b0110);
        set_data(2, d1);
        for (int c = 0; c < 5; c++) begin
            bus.cd_valid_i = (c < 2) ? 4'b0110 : 4'b0100;
            bus.cd_last_i  = (c == 1) ? 4'b0010 : 4'b0000;
            set_data(1, {$urandom, $urandom});
            @(negedge clk);
            checks++; if (bus.cd_ready_o !== ((c < 2) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL stall_ready c=%0d got %b", c, bus.cd_ready_o); end
            checks++; if (bus.usr_valid_o !== 2'b10) begin errors++; $display("FAIL stall_uvalid c=%0d got %b exp 10", c, bus.usr_valid_o); end
            if (bus.usr_valid_o[1] && bus.usr_ready_i[1]) fwd++;
            tick();
        end
        bus.usr_ready_i = 2'b11;
        bus.cd_valid_i = 4'b0100; bus.cd_last_i = 4'b0000;
        @(negedge clk);
        checks++; if (bus.cd_ready_o !== 4'b0100) begin errors++; $display("FAIL stall_resume_ready got %b exp 0100", bus.cd_ready_o); end
        checks++; if (bus.usr_data_o !== d1) begin errors++; $display("FAIL stall_data1 got %h exp %h", bus.usr_data_o, d1); end
        if (bus.usr_valid_o[1] && bus.usr_ready_i[1]) fwd++;
        tick();
        bus.cd_last_i = 4'b0100; set_data(2, d2);
        @(negedge clk);
        checks++; if (bus.usr_data_o !== d2) begin errors++; $display("FAIL stall_data2 got %h exp %h", bus.usr_data_o, d2); end
        if (bus.usr_valid_o[1] && bus.usr_ready_i[1]) fwd++;
        tick();
        idle();
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL stall_pop got %0b exp 0", bus.busy_o); end
        checks++; if (fwd !== 2) begin errors++; $display("FAIL stall_beats got %0d exp 2", fwd); end
        tick();
    endtask

    task automatic test_full();
        logic [W-1:0] r;
        bus.usr_ready_i = 2'b00;
        for (int k = 0; k < 5; k++) begin
            bus.push_valid_i = 1'b1;
            bus.push_user_i  = (k == 4) ? 1'b0 : k[0:0];
            bus.push_first_i = (k == 4) ? 2'd3 : k[1:0];
            bus.push_avail_i = (k == 4) ? 4'b1000 : 4'(1 << k);
            @(negedge clk);
            checks++; if (bus.push_ready_o !== (k < 4)) begin errors++; $display("FAIL full_push_ready k=%0d got %0b", k, bus.push_ready_o); end
            tick();
        end
        idle();
        bus.usr_ready_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < LB; b++) begin
                r = {$urandom, $urandom};
                bus.cd_valid_i = 4'(1 << k);
                bus.cd_last_i  = (b == LB - 1) ? 4'(1 << k) : 4'b0000;
                set_data(k, r);
                @(negedge clk);
                checks++; if (bus.cd_ready_o !== 4'(1 << k)) begin errors++; $display("FAIL full_order_ready k=%0d got %b", k, bus.cd_ready_o); end
                checks++; if (bus.usr_valid_o !== 2'(1 << (k % 2))) begin errors++; $display("FAIL full_uvalid k=%0d got %b", k, bus.usr_valid_o); end
                checks++; if (bus.usr_data_o !== r) begin errors++; $display("FAIL full_data k=%0d got %h exp %h", k, bus.usr_data_o, r); end
                tick();
            end
            idle();
            @(negedge clk);
            if (k == 0) begin
                checks++; if (bus.push_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %0b exp 1", bus.push_ready_o); end
            end
            checks++; if (bus.busy_o !== (k < 3)) begin errors++; $display("FAIL full_busy k=%0d got %0b", k, bus.busy_o); end
            tick();
        end
    endtask

    task automatic test_avail_zero();
        bus.usr_ready_i = 2'b11;
        push_one(0, 0, 4'b0000);
        bus.cd_valid_i = 4'b1111; bus.cd_last_i = 4'b1111;
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL az_busy got %0b exp 1", bus.busy_o); end
        checks++; if (bus.cd_ready_o !== 4'b0000) begin errors++; $display("FAIL az_ready got %b exp 0000", bus.cd_ready_o); end
        checks++; if (bus.usr_valid_o !== 2'b00) begin errors++; $display("FAIL az_uvalid got %b exp 00", bus.usr_valid_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL az_pop got %0b exp 0", bus.busy_o); end
        checks++; if (bus.cd_ready_o !== 4'b0000) begin errors++; $display("FAIL az_ready2 got %b exp 0000", bus.cd_ready_o); end
        tick();
        idle();
    endtask

    task automatic test_beat_err();
        bus.usr_ready_i = 2'b11;
        push_one(0, 2, 4'b0100);
        bus.cd_valid_i = 4'b0100; bus.cd_last_i = 4'b0100;
        @(negedge clk);
        checks++; if (bus.cd_ready_o !== 4'b0100) begin errors++; $display("FAIL err_ready got %b exp 0100", bus.cd_ready_o); end
        checks++; if (bus.beat_err_o !== 1'b0) begin errors++; $display("FAIL err_early got %0b exp 0", bus.beat_err_o); end
        tick();
        idle();
        @(negedge clk);
        checks++; if (bus.beat_err_o !== 1'b1) begin errors++; $display("FAIL err_pulse got %0b exp 1", bus.beat_err_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL err_pop got %0b exp 0", bus.busy_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.beat_err_o !== 1'b0) begin errors++; $display("FAIL err_width got %0b exp 0", bus.beat_err_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        bus.usr_ready_i = 2'b11;
        push_one(1, 2, 4'b0110);
        bus.cd_valid_i = 4'b0110; bus.cd_last_i = 4'b0000;
        tick();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b exp 0", bus.busy_o); end
        checks++; if (bus.cd_ready_o !== 4'b0000) begin errors++; $display("FAIL rmid_ready got %b exp 0000", bus.cd_ready_o); end
        checks++; if (bus.push_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_push_ready got %0b exp 1", bus.push_ready_o); end
        tick();
        push_one(1, 2, 4'b0110);
        for (int b = 0; b < LB; b++) begin
            d = {$urandom, $urandom};
            bus.cd_valid_i = 4'b0110;
            bus.cd_last_i  = (b == LB - 1) ? 4'b0110 : 4'b0000;
            set_data(2, d);
            set_data(1, {$urandom, $urandom});
            @(negedge clk);
            checks++; if (bus.usr_valid_o !== 2'b10) begin errors++; $display("FAIL rmid_uvalid b=%0d got %b", b, bus.usr_valid_o); end
            checks++; if (bus.usr_data_o !== d) begin errors++; $display("FAIL rmid_data b=%0d got %h exp %h", b, bus.usr_data_o, d); end
            checks++; if (bus.beat_err_o !== 1'b0) begin errors++; $display("FAIL rmid_err b=%0d got %0b exp 0", b, bus.beat_err_o); end
            tick();
        end
        idle();
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rmid_pop got %0b exp 0", bus.busy_o); end
        checks++; if (bus.beat_err_o !== 1'b0) begin errors++; $display("FAIL rmid_err_end got %0b exp 0", bus.beat_err_o); end
        tick();
    endtask

    // Reference: a descriptor queue plus, for the head line, how many beats
    // each port has delivered and whether its line is complete.
    task automatic test_random();
        entry_t mq[$];
        entry_t h;
        int mcnt[NP];
        bit mdone[NP];
        logic [NP-1:0] exp_cr;
        logic [NU-1:0] exp_uv;
        logic exp_pr, exp_busy, all_done;
        logic [W-1:0] exp_data;
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        for (int i = 0; i < NP; i++) begin mcnt[i] = 0; mdone[i] = 0; end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bus.push_valid_i = ($urandom_range(0, 2) == 0);
            bus.push_user_i  = 1'($urandom_range(0, NU - 1));
            bus.push_first_i = 2'($urandom_range(0, NP - 1));
            bus.push_avail_i = 4'($urandom_range(0, 15));
            bus.usr_ready_i  = 2'($urandom_range(0, 3));
            for (int i = 0; i < NP; i++) begin
                bus.cd_valid_i[i] = 1'($urandom_range(0, 1));
                bus.cd_last_i[i]  = (mcnt[i] == LB - 1);
                set_data(i, {$urandom, $urandom});
            end
            @(negedge clk);
            exp_pr = (mq.size() < DEPTH);
            exp_busy = (mq.size() > 0);
            exp_cr = '0;
            exp_uv = '0;
            exp_data = '0;
            if (exp_busy) begin
                h = mq[0];
                for (int i = 0; i < NP; i++)
                    if (h.avail[i] && !mdone[i] && (i != h.first || bus.usr_ready_i[h.user])) exp_cr[i] = 1'b1;
                if (h.avail[h.first] && !mdone[h.first] && bus.cd_valid_i[h.first]) exp_uv[h.user] = 1'b1;
                exp_data = bus.cd_data_i[h.first*W +: W];
            end
            checks++; if (bus.push_ready_o !== exp_pr) begin errors++; $display("FAIL rnd_push_ready cyc=%0d got %0b exp %0b", cyc, bus.push_ready_o, exp_pr); end
            checks++; if (bus.busy_o !== exp_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got %0b exp %0b", cyc, bus.busy_o, exp_busy); end
            checks++; if (bus.cd_ready_o !== exp_cr) begin errors++; $display("FAIL rnd_cd_ready cyc=%0d got %b exp %b", cyc, bus.cd_ready_o, exp_cr); end
            checks++; if (bus.usr_valid_o !== exp_uv) begin errors++; $display("FAIL rnd_usr_valid cyc=%0d got %b exp %b", cyc, bus.usr_valid_o, exp_uv); end
            checks++; if (bus.beat_err_o !== 1'b0) begin errors++; $display("FAIL rnd_beat_err cyc=%0d got %0b exp 0", cyc, bus.beat_err_o); end
            if (exp_uv != '0) begin
                checks++; if (bus.usr_data_o !== exp_data) begin errors++; $display("FAIL rnd_usr_data cyc=%0d got %h exp %h", cyc, bus.usr_data_o, exp_data); end
                checks++; if (bus.usr_last_o !== (mcnt[h.first] == LB - 1)) begin errors++; $display("FAIL rnd_usr_last cyc=%0d got %0b", cyc, bus.usr_last_o); end
            end
            if (exp_busy) begin
                for (int i = 0; i < NP; i++) begin
                    if (exp_cr[i] && bus.cd_valid_i[i]) begin
                        if (bus.cd_last_i[i]) begin mdone[i] = 1; mcnt[i] = 0; end
                        else mcnt[i]++;
                    end
                end
                all_done = 1'b1;
                for (int i = 0; i < NP; i++) if (h.avail[i] && !mdone[i]) all_done = 1'b0;
                if (all_done) begin
                    mq.delete(0);
                    for (int i = 0; i < NP; i++) begin mcnt[i] = 0; mdone[i] = 0; end
                end
            end
            if (bus.push_valid_i && exp_pr)
                mq.push_back('{user: bus.push_user_i, first: bus.push_first_i, avail: bus.push_avail_i});
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        bus.usr_ready_i = '0;
        test_reset();
        test_basic();
        test_stall();
        test_full();
        test_avail_zero();
        test_beat_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
